// File: rtl/fft_bf_pair_sched.sv
// Radix-2 first-stage pairing scheduler: buffers half a frame, emits sums on the
// second half and replays the stored diffs while the next frame fills (SDF style).
module fft_bf_pair_sched #(
   parameter int unsigned W     = 13,
   parameter int unsigned LANES = 16,
   parameter int unsigned HALF  = 16
) (
   input  logic                                   clk,
   input  logic                                   rstn,
   input  logic                                   valid_in,
   input  logic                                   flush,
   input  logic [LANES-1:0][W-1:0]                din_re,
   input  logic [LANES-1:0][W-1:0]                din_im,
   output logic                                   valid_out,
   output logic [LANES-1:0][W:0]                  dout_re,
   output logic [LANES-1:0][W:0]                  dout_im,
   output logic [$clog2(2*HALF)-1:0]              out_idx,
   output logic                                   out_last,
   output logic                                   pending
);

   localparam int unsigned CW = $clog2(2 * HALF);
   localparam int unsigned KW = $clog2(HALF);
   localparam int unsigned DW = W + 1;

   typedef logic [LANES-1:0][DW-1:0] blk_t;

   blk_t            mem_re [HALF];
   blk_t            mem_im [HALF];

   logic [CW-1:0]   cnt_q, cnt_d;
   logic            pending_d;
   logic            valid_d;
   blk_t            dout_re_d, dout_im_d;
   logic [CW-1:0]   idx_d;
   logic            last_d;

   logic [KW-1:0]   k;
   logic            fill;
   logic            last_k;
   blk_t            rd_re, rd_im;
   blk_t            dx_re, dx_im;
   blk_t            sum_re, sum_im;
   blk_t            dif_re, dif_im;
   logic            wr_en;
   blk_t            wr_re, wr_im;

   // Slot addressing and the per-lane butterfly arithmetic at W+1 bits.
   always_comb begin
      k      = cnt_q[KW-1:0];
      fill   = ~cnt_q[CW-1];
      last_k = (k == KW'(HALF - 1));
      rd_re  = mem_re[k];
      rd_im  = mem_im[k];
      for (int l = 0; l < LANES; l++) begin
         dx_re[l]  = {din_re[l][W-1], din_re[l]};
         dx_im[l]  = {din_im[l][W-1], din_im[l]};
         sum_re[l] = rd_re[l] + dx_re[l];
         sum_im[l] = rd_im[l] + dx_im[l];
         dif_re[l] = rd_re[l] - dx_re[l];
         dif_im[l] = rd_im[l] - dx_im[l];
      end
   end

   // Next-state and output selection for fill, pair and flush steps.
   always_comb begin
      cnt_d     = cnt_q;
      pending_d = pending;
      valid_d   = 1'b0;
      dout_re_d = dout_re;
      dout_im_d = dout_im;
      idx_d     = out_idx;
      last_d    = 1'b0;
      wr_en     = 1'b0;
      wr_re     = dx_re;
      wr_im     = dx_im;

      if (valid_in) begin
         cnt_d = cnt_q + CW'(1);
         wr_en = 1'b1;
         if (fill) begin
            if (pending) begin
               valid_d   = 1'b1;
               dout_re_d = rd_re;
               dout_im_d = rd_im;
               idx_d     = {1'b1, k};
               last_d    = last_k;
            end
            if (last_k) begin
               pending_d = 1'b0;
            end
         end else begin
            valid_d   = 1'b1;
            dout_re_d = sum_re;
            dout_im_d = sum_im;
            idx_d     = {1'b0, k};
            wr_re     = dif_re;
            wr_im     = dif_im;
            if (last_k) begin
               pending_d = 1'b1;
            end
         end
      end else if (flush && pending) begin
         // Drain one stored diff; the partial new frame is abandoned.
         valid_d   = 1'b1;
         dout_re_d = rd_re;
         dout_im_d = rd_im;
         idx_d     = {1'b1, k};
         last_d    = last_k;
         if (last_k) begin
            cnt_d     = '0;
            pending_d = 1'b0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q     <= '0;
         pending   <= 1'b0;
         valid_out <= 1'b0;
         dout_re   <= '0;
         dout_im   <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         pending   <= pending_d;
         valid_out <= valid_d;
         dout_re   <= dout_re_d;
         dout_im   <= dout_im_d;
         out_idx   <= idx_d;
         out_last  <= last_d;
      end
   end

   // Half-frame buffer: contents are never emitted before being written.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_re[k] <= wr_re;
         mem_im[k] <= wr_im;
      end
   end

endmodule

// File: tb/tb_fft_bf_pair_sched.sv
// Directed bench for fft_bf_pair_sched: frame-indexed golden sums/diffs, stalls,
// flush collisions and mid-frame reset.
module tb_fft_bf_pair_sched;

   localparam int unsigned W     = 13;
   localparam int unsigned LANES = 16;
   localparam int unsigned HALF  = 16;
   localparam int unsigned CW    = $clog2(2 * HALF);
   localparam int unsigned DW    = W + 1;

   typedef logic [LANES-1:0][DW-1:0] blk_t;

   logic                      clk;
   logic                      rstn;
   logic                      valid_in;
   logic                      flush;
   logic [LANES-1:0][W-1:0]   din_re;
   logic [LANES-1:0][W-1:0]   din_im;
   logic                      valid_out;
   blk_t                      dout_re;
   blk_t                      dout_im;
   logic [CW-1:0]             out_idx;
   logic                      out_last;
   logic                      pending;

   int checks   = 0;
   int failures = 0;

   fft_bf_pair_sched #(.W(W), .LANES(LANES), .HALF(HALF)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .valid_in  (valid_in),
      .flush     (flush),
      .din_re    (din_re),
      .din_im    (din_im),
      .valid_out (valid_out),
      .dout_re   (dout_re),
      .dout_im   (dout_im),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .pending   (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Sample value for pattern p, frame fr, block j (0..31), lane l.
   function automatic int sval(int p, int fr, int j, int l, bit im);
      case (p)
         0:       return im ? (l * 3 - j) : (j * 16 + l);
         1:       return (j < int'(HALF)) ? (im ? 4095 : -4096) : (im ? -4096 : 4095);
         2:       return im ? 4095 : -4096;
         default: return ((fr * 1103 + j * 97 + l * 61 + (im ? 523 : 0)) % 8192) - 4096;
      endcase
   endfunction

   // Golden sum or diff (first - second) of pair k of a frame.
   function automatic blk_t ex(int p, int fr, int k, bit is_sum, bit im);
      blk_t r;
      for (int l = 0; l < int'(LANES); l++) begin
         int a, b;
         a = sval(p, fr, k, l, im);
         b = sval(p, fr, k + int'(HALF), l, im);
         r[l] = is_sum ? DW'(a + b) : DW'(a - b);
      end
      return r;
   endfunction

   function automatic blk_t splat(int v);
      blk_t r;
      for (int l = 0; l < int'(LANES); l++) r[l] = DW'(v);
      return r;
   endfunction

   task automatic drive(input bit v, input bit f, input int p, input int fr, input int j);
      valid_in = v;
      flush    = f;
      for (int l = 0; l < int'(LANES); l++) begin
         din_re[l] = W'(sval(p, fr, j, l, 1'b0));
         din_im[l] = W'(sval(p, fr, j, l, 1'b1));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      drive(1'b1, 1'b0, 0, 0, 0);
      drive(1'b1, 1'b0, 0, 0, 1);
      checks++;
      if (valid_out !== 1'b0 || pending !== 1'b0 || out_last !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl valid=%b pending=%b last=%b required 0 0 0", valid_out, pending, out_last);
      end
      checks++;
      if (dout_re !== '0 || dout_im !== '0 || out_idx !== '0) begin
         failures++;
         $display("FAIL reset_data re=%h im=%h idx=%0d required all zero", dout_re, dout_im, out_idx);
      end
      rstn = 1'b1;
      for (int j = 0; j < int'(HALF); j++) begin
         drive(1'b1, 1'b0, 0, 0, j);
         checks++;
         if (valid_out !== 1'b0 || pending !== 1'b0) begin
            failures++;
            $display("FAIL first_half_quiet j=%0d valid=%b pending=%b required 0 0", j, valid_out, pending);
         end
      end
   endtask

   // Continues the frame begun in test_reset, then flushes its diffs.
   task automatic test_one_frame;
      blk_t m256;
      m256 = splat(-256);
      for (int j = int'(HALF); j < 2 * int'(HALF); j++) begin
         int k;
         k = j - int'(HALF);
         drive(1'b1, 1'b0, 0, 0, j);
         checks++;
         if (valid_out !== 1'b1 || out_idx !== CW'(k) || out_last !== 1'b0) begin
            failures++;
            $display("FAIL frame_sum_ctrl k=%0d valid=%b idx=%0d last=%b required 1 %0d 0", k, valid_out, out_idx, out_last, k);
         end
         checks++;
         if (dout_re[3] !== DW'(2 * (k * 16 + 3) + 256) || dout_re !== ex(0, 0, k, 1'b1, 1'b0)
             || dout_im !== ex(0, 0, k, 1'b1, 1'b1)) begin
            failures++;
            $display("FAIL frame_sum_data k=%0d re=%h im=%h required re=%h im=%h", k, dout_re, dout_im,
                     ex(0, 0, k, 1'b1, 1'b0), ex(0, 0, k, 1'b1, 1'b1));
         end
      end
      checks++;
      if (pending !== 1'b1) begin
         failures++;
         $display("FAIL frame_pending_set got=%b required 1", pending);
      end
      for (int k = 0; k < int'(HALF); k++) begin
         drive(1'b0, 1'b1, 0, 0, 0);
         checks++;
         if (valid_out !== 1'b1 || out_idx !== CW'(int'(HALF) + k) || out_last !== (k == int'(HALF) - 1)
             || pending !== (k != int'(HALF) - 1)) begin
            failures++;
            $display("FAIL flush_diff_ctrl k=%0d valid=%b idx=%0d last=%b pending=%b", k, valid_out, out_idx, out_last, pending);
         end
         checks++;
         if (dout_re !== m256 || dout_im !== ex(0, 0, k, 1'b0, 1'b1)) begin
            failures++;
            $display("FAIL flush_diff_data k=%0d re=%h im=%h required re=%h im=%h", k, dout_re, dout_im,
                     m256, ex(0, 0, k, 1'b0, 1'b1));
         end
      end
      drive(1'b0, 1'b1, 0, 0, 0);
      checks++;
      if (valid_out !== 1'b0 || pending !== 1'b0) begin
         failures++;
         $display("FAIL flush_idle valid=%b pending=%b required 0 0", valid_out, pending);
      end
   endtask

   task automatic test_back_to_back;
      int nv;
      nv = 0;
      for (int g = 0; g < 6 * int'(HALF); g++) begin
         int fr, j;
         bit ev;
         int eidx;
         bit elast;
         blk_t er, ei;
         fr = g / (2 * int'(HALF));
         j  = g % (2 * int'(HALF));
         ev = 1'b0; eidx = 0; elast = 1'b0; er = '0; ei = '0;
         if (j >= int'(HALF)) begin
            ev = 1'b1; eidx = j - int'(HALF);
            er = ex(3, fr, eidx, 1'b1, 1'b0); ei = ex(3, fr, eidx, 1'b1, 1'b1);
         end else if (fr > 0) begin
            ev = 1'b1; eidx = int'(HALF) + j; elast = (j == int'(HALF) - 1);
            er = ex(3, fr - 1, j, 1'b0, 1'b0); ei = ex(3, fr - 1, j, 1'b0, 1'b1);
         end
         drive(1'b1, 1'b0, 3, fr, j);
         if (valid_out === 1'b1) nv++;
         checks++;
         if (valid_out !== ev) begin
            failures++;
            $display("FAIL b2b_valid g=%0d got=%b required %b", g, valid_out, ev);
         end else if (ev) begin
            checks++;
            if (out_idx !== CW'(eidx) || out_last !== elast || dout_re !== er || dout_im !== ei) begin
               failures++;
               $display("FAIL b2b_data g=%0d idx=%0d last=%b re=%h required idx=%0d last=%b re=%h", g, out_idx,
                        out_last, dout_re, eidx, elast, er);
            end
         end
      end
      for (int k = 0; k < int'(HALF); k++) begin
         drive(1'b0, 1'b1, 3, 0, 0);
         if (valid_out === 1'b1) nv++;
         checks++;
         if (valid_out !== 1'b1 || out_idx !== CW'(int'(HALF) + k) || dout_re !== ex(3, 2, k, 1'b0, 1'b0)
             || dout_im !== ex(3, 2, k, 1'b0, 1'b1)) begin
            failures++;
            $display("FAIL b2b_flush k=%0d valid=%b idx=%0d re=%h required re=%h", k, valid_out, out_idx,
                     dout_re, ex(3, 2, k, 1'b0, 1'b0));
         end
      end
      checks++;
      if (nv != 6 * int'(HALF)) begin
         failures++;
         $display("FAIL b2b_count got=%0d required %0d", nv, 6 * int'(HALF));
      end
   endtask

   task automatic test_widths;
      for (int p = 1; p <= 2; p++) begin
         int s_re, s_im, d_re, d_im;
         s_re = (p == 1) ? -1 : -8192;
         s_im = (p == 1) ? -1 : 8190;
         d_re = (p == 1) ? -8191 : 0;
         d_im = (p == 1) ? 8191 : 0;
         for (int j = 0; j < 2 * int'(HALF); j++) begin
            drive(1'b1, 1'b0, p, 0, j);
            if (j >= int'(HALF)) begin
               checks++;
               if (valid_out !== 1'b1 || dout_re !== splat(s_re) || dout_im !== splat(s_im)) begin
                  failures++;
                  $display("FAIL width_sum p=%0d j=%0d valid=%b re0=%h im0=%h required %h %h", p, j, valid_out,
                           dout_re[0], dout_im[0], DW'(s_re), DW'(s_im));
               end
            end
         end
         for (int k = 0; k < int'(HALF); k++) begin
            drive(1'b0, 1'b1, p, 0, 0);
            checks++;
            if (valid_out !== 1'b1 || dout_re !== splat(d_re) || dout_im !== splat(d_im)) begin
               failures++;
               $display("FAIL width_diff p=%0d k=%0d valid=%b re0=%h im0=%h required %h %h", p, k, valid_out,
                        dout_re[0], dout_im[0], DW'(d_re), DW'(d_im));
            end
         end
      end
   endtask

   task automatic test_stalls;
      int g, k;
      g = 0;
      for (int c = 0; c < 1000 && g < 4 * int'(HALF); c++) begin
         if ($urandom_range(0, 2) == 0) begin
            drive(1'b0, 1'b0, 3, 0, 0);
            checks++;
            if (valid_out !== 1'b0) begin
               failures++;
               $display("FAIL stall_gap c=%0d valid=%b required 0", c, valid_out);
            end
         end else begin
            int fr, j;
            bit ev;
            blk_t er;
            fr = 10 + g / (2 * int'(HALF));
            j  = g % (2 * int'(HALF));
            ev = (j >= int'(HALF)) || (fr > 10);
            er = (j >= int'(HALF)) ? ex(3, fr, j - int'(HALF), 1'b1, 1'b0) : ex(3, fr - 1, j, 1'b0, 1'b0);
            drive(1'b1, 1'($urandom_range(0, 1)), 3, fr, j);
            checks++;
            if (valid_out !== ev || (ev && dout_re !== er)) begin
               failures++;
               $display("FAIL stall_data g=%0d valid=%b re=%h required %b %h", g, valid_out, dout_re, ev, er);
            end
            g++;
         end
      end
      checks++;
      if (g != 4 * int'(HALF)) begin
         failures++;
         $display("FAIL stall_budget blocks=%0d required %0d", g, 4 * int'(HALF));
      end
      k = 0;
      for (int c = 0; c < 1000 && k < int'(HALF); c++) begin
         if ($urandom_range(0, 2) == 0) begin
            drive(1'b0, 1'b0, 3, 0, 0);
            checks++;
            if (valid_out !== 1'b0) begin
               failures++;
               $display("FAIL stall_flush_gap c=%0d valid=%b required 0", c, valid_out);
            end
         end else begin
            drive(1'b0, 1'b1, 3, 0, 0);
            checks++;
            if (valid_out !== 1'b1 || out_idx !== CW'(int'(HALF) + k) || dout_im !== ex(3, 11, k, 1'b0, 1'b1)) begin
               failures++;
               $display("FAIL stall_flush k=%0d valid=%b idx=%0d im=%h required %h", k, valid_out, out_idx,
                        dout_im, ex(3, 11, k, 1'b0, 1'b1));
            end
            k++;
         end
      end
      checks++;
      if (k != int'(HALF) || pending !== 1'b0) begin
         failures++;
         $display("FAIL stall_flush_end diffs=%0d pending=%b required %0d 0", k, pending, HALF);
      end
   endtask

   task automatic test_reset_mid;
      for (int j = 0; j < int'(HALF) + 5; j++) drive(1'b1, 1'b0, 3, 20, j);
      rstn = 1'b0;
      drive(1'b1, 1'b0, 3, 20, int'(HALF) + 5);
      checks++;
      if (valid_out !== 1'b0 || pending !== 1'b0) begin
         failures++;
         $display("FAIL midreset valid=%b pending=%b required 0 0", valid_out, pending);
      end
      rstn = 1'b1;
      for (int j = 0; j < 7; j++) drive(1'b1, 1'b0, 3, 21, j);
      for (int c = 0; c < 3; c++) begin
         drive(1'b0, 1'b1, 3, 0, 0);
         checks++;
         if (valid_out !== 1'b0 || pending !== 1'b0) begin
            failures++;
            $display("FAIL idle_flush c=%0d valid=%b pending=%b required 0 0", c, valid_out, pending);
         end
      end
      for (int j = 7; j < 2 * int'(HALF); j++) begin
         bit ev;
         ev = (j >= int'(HALF));
         drive(1'b1, 1'b0, 3, 21, j);
         checks++;
         if (valid_out !== ev || (ev && (dout_re !== ex(3, 21, j - int'(HALF), 1'b1, 1'b0)
                                         || dout_im !== ex(3, 21, j - int'(HALF), 1'b1, 1'b1)))) begin
            failures++;
            $display("FAIL after_reset_sum j=%0d valid=%b re=%h required %b", j, valid_out, dout_re, ev);
         end
      end
      for (int k = 0; k < int'(HALF); k++) begin
         drive(1'b0, 1'b1, 3, 0, 0);
         checks++;
         if (valid_out !== 1'b1 || out_last !== (k == int'(HALF) - 1) || dout_re !== ex(3, 21, k, 1'b0, 1'b0)) begin
            failures++;
            $display("FAIL after_reset_diff k=%0d valid=%b last=%b re=%h required %h", k, valid_out, out_last,
                     dout_re, ex(3, 21, k, 1'b0, 1'b0));
         end
      end
   endtask

   initial begin
      rstn     = 1'b0;
      valid_in = 1'b0;
      flush    = 1'b0;
      din_re   = '0;
      din_im   = '0;
      test_reset;
      test_one_frame;
      test_back_to_back;
      test_widths;
      test_stalls;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule
